// File: rtl/tinker_program_loader_if.sv
// Instruction-tuple handshake plus memory byte-write port of the Tinker program loader.
// The host drives tuples through master; the loader consumes them and drives memory through slave.
interface tinker_program_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [11:0] in_lit;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs, in_rt, in_lit,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs, in_rt, in_lit,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/tinker_program_loader.sv
// Encodes Tinker instruction tuples into 32-bit words and writes them little-endian,
// one byte per cycle, into core memory starting at the fetch reset address.
module tinker_program_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h2000,
  parameter logic [63:0] MEM_BYTES = 64'd524288
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  tinker_program_loader_if.slave  bus,
  output logic [31:0]             instr_word_o,
  output logic [15:0]             instr_count_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_opcode_o,
  output logic                    err_full_o
);

  typedef enum logic [1:0] {IDLE, READY, WRITE} state_e;

  localparam logic [4:0] OP_HALT    = 5'h0F;
  localparam bit         START_FITS = (BASE_ADDR + 64'd4) <= MEM_BYTES;

  state_e      state_q;
  logic [1:0]  byte_idx_q;
  logic [63:0] addr_q;
  logic [31:0] word_q;
  logic [15:0] count_q;
  logic        done_q, err_opcode_q, err_full_q, busy_q, in_ready_q;
  logic        mem_we_q;
  logic [63:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;

  logic [31:0] word_d;
  logic [15:0] count_d;
  logic [63:0] addr_d;
  logic [1:0]  byte_idx_d;
  logic        op_illegal, full_d;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    logic lit_form, rd_source, halt;
    lit_form   = bus.in_opcode inside {5'h19, 5'h1B, 5'h05, 5'h07, 5'h12, 5'h0A, 5'h10, 5'h13};
    rd_source  = bus.in_opcode inside {5'h19, 5'h1B, 5'h05, 5'h07, 5'h12};
    halt       = bus.in_opcode == OP_HALT;
    op_illegal = bus.in_opcode >= 5'h1E;
    word_d     = {bus.in_opcode,
                  halt                ? 5'd0  : bus.in_rd,
                  (halt || rd_source) ? 5'd0  : bus.in_rs,
                  (halt || lit_form)  ? 5'd0  : bus.in_rt,
                  lit_form            ? bus.in_lit : 12'd0};
    count_d    = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    addr_d     = addr_q + 64'd4;
    full_d     = (addr_d + 64'd4) > MEM_BYTES;
    byte_idx_d = byte_idx_q + 2'd1;
  end

  // NOTE: state and outputs update with non-blocking assignments so every flop sees the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      byte_idx_q   <= 2'd0;
      addr_q       <= BASE_ADDR;
      word_q       <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      err_opcode_q <= 1'b0;
      err_full_q   <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        // Restart wins over everything, including a word half-way through its bytes.
        addr_q       <= BASE_ADDR;
        byte_idx_q   <= 2'd0;
        count_q      <= '0;
        err_opcode_q <= 1'b0;
        mem_we_q     <= 1'b0;
        state_q      <= START_FITS ? READY : IDLE;
        busy_q       <= START_FITS;
        in_ready_q   <= START_FITS;
        err_full_q   <= !START_FITS;
      end else begin
        unique case (state_q)
          READY: begin
            if (bus.in_valid) begin
              if (op_illegal) begin
                err_opcode_q <= 1'b1;
              end else begin
                word_q      <= word_d;
                state_q     <= WRITE;
                byte_idx_q  <= 2'd0;
                in_ready_q  <= 1'b0;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= addr_q;
                mem_wdata_q <= word_d[7:0];
              end
            end
          end
          WRITE: begin
            if (byte_idx_q != 2'd3) begin
              byte_idx_q  <= byte_idx_d;
              mem_addr_q  <= addr_q + {62'd0, byte_idx_d};
              mem_wdata_q <= word_q[{byte_idx_d, 3'b000} +: 8];
            end else begin
              mem_we_q   <= 1'b0;
              byte_idx_q <= 2'd0;
              addr_q     <= addr_d;
              count_q    <= count_d;
              if (word_q[31:27] == OP_HALT) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else if (full_d) begin
                err_full_q <= 1'b1;
                state_q    <= IDLE;
                busy_q     <= 1'b0;
              end else begin
                state_q    <= READY;
                in_ready_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign instr_word_o   = word_q;
  assign instr_count_o  = count_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_opcode_o   = err_opcode_q;
  assign err_full_o     = err_full_q;

endmodule

// File: tb/tb_tinker_program_loader.sv
// Directed bench for tinker_program_loader: encoding table, byte stream, halt, illegal opcode,
// memory-full, start abort and asynchronous reset mid-write.
module tb_tinker_program_loader;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [11:0] lit;
    logic [31:0] word;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  data;
    logic        rdy;
    logic [15:0] cnt;
    logic [31:0] word;
    logic        done;
    logic        ef;
    logic        eo;
    logic        busy;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  start_v = '0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_opcode = '0, in_rd = '0, in_rs = '0, in_rt = '0;
  logic [11:0] in_lit = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tinker_program_loader_if bus0();
  tinker_program_loader_if bus1();
  tinker_program_loader_if bus2();

  assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;  assign bus2.in_valid = in_valid;
  assign bus0.in_opcode = in_opcode; assign bus1.in_opcode = in_opcode; assign bus2.in_opcode = in_opcode;
  assign bus0.in_rd = in_rd; assign bus1.in_rd = in_rd; assign bus2.in_rd = in_rd;
  assign bus0.in_rs = in_rs; assign bus1.in_rs = in_rs; assign bus2.in_rs = in_rs;
  assign bus0.in_rt = in_rt; assign bus1.in_rt = in_rt; assign bus2.in_rt = in_rt;
  assign bus0.in_lit = in_lit; assign bus1.in_lit = in_lit; assign bus2.in_lit = in_lit;

  logic [31:0] w0, w1, w2;
  logic [15:0] c0, c1, c2;
  logic b0, b1, b2, d0, d1, d2, eo0, eo1, eo2, ef0, ef1, ef2;

  tinker_program_loader dut0 (
    .clk(clk), .reset(reset), .start_i(start_v[0]), .bus(bus0.slave),
    .instr_word_o(w0), .instr_count_o(c0), .busy_o(b0), .done_o(d0),
    .err_opcode_o(eo0), .err_full_o(ef0)
  );

  tinker_program_loader #(.BASE_ADDR(64'h2000), .MEM_BYTES(64'h2008)) dut1 (
    .clk(clk), .reset(reset), .start_i(start_v[1]), .bus(bus1.slave),
    .instr_word_o(w1), .instr_count_o(c1), .busy_o(b1), .done_o(d1),
    .err_opcode_o(eo1), .err_full_o(ef1)
  );

  tinker_program_loader #(.BASE_ADDR(64'h2000), .MEM_BYTES(64'h2003)) dut2 (
    .clk(clk), .reset(reset), .start_i(start_v[2]), .bus(bus2.slave),
    .instr_word_o(w2), .instr_count_o(c2), .busy_o(b2), .done_o(d2),
    .err_opcode_o(eo2), .err_full_o(ef2)
  );

  function automatic obs_t obs(input int sel);
    obs_t o;
    case (sel)
      1:       o = '{we: bus1.mem_we, addr: bus1.mem_addr, data: bus1.mem_wdata, rdy: bus1.in_ready,
                     cnt: c1, word: w1, done: d1, ef: ef1, eo: eo1, busy: b1};
      2:       o = '{we: bus2.mem_we, addr: bus2.mem_addr, data: bus2.mem_wdata, rdy: bus2.in_ready,
                     cnt: c2, word: w2, done: d2, ef: ef2, eo: eo2, busy: b2};
      default: o = '{we: bus0.mem_we, addr: bus0.mem_addr, data: bus0.mem_wdata, rdy: bus0.in_ready,
                     cnt: c0, word: w0, done: d0, ef: ef0, eo: eo0, busy: b0};
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int sel);
    start_v[sel] = 1'b1;
    tick();
    start_v = '0;
  endtask

  // Hand one tuple to DUT sel and follow its four bytes and the cycle after them.
  task automatic send(input int sel, input vec_t v, input logic [63:0] base,
                      input logic [15:0] exp_cnt, input bit exp_halt, input bit exp_full);
    obs_t o;
    int   n;
    bit   exp_rdy;
    n = 0;
    o = obs(sel);
    while (!o.rdy && n < 20) begin
      tick();
      n++;
      o = obs(sel);
    end
    check("ready_wait", 64'(o.rdy), 64'd1);
    in_opcode = v.op; in_rd = v.rd; in_rs = v.rs; in_rt = v.rt; in_lit = v.lit;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    o = obs(sel);
    check("instr_word", 64'(o.word), 64'(v.word));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        o = obs(sel);
      end
      check("byte_we", 64'(o.we), 64'd1);
      check("byte_addr", o.addr, base + 64'(i));
      check("byte_data", 64'(o.data), 64'(v.word[8*i +: 8]));
    end
    tick();
    o = obs(sel);
    exp_rdy = !(exp_halt || exp_full);
    check("post_we", 64'(o.we), 64'd0);
    check("post_count", 64'(o.cnt), 64'(exp_cnt));
    check("post_ready", 64'(o.rdy), 64'(exp_rdy));
    check("post_done", 64'(o.done), 64'(exp_halt));
    check("post_err_full", 64'(o.ef), 64'(exp_full));
    check("post_busy", 64'(o.busy), 64'(exp_rdy));
  endtask

  initial begin
    vec_t        vecs[6];
    vec_t        halt_v, abort_v;
    obs_t        o;
    logic [63:0] exp_addr;
    logic [15:0] exp_cnt;

    vecs[0] = '{op: 5'h18, rd: 5'd1,  rs: 5'd2,  rt: 5'd3,  lit: 12'h000, word: 32'hC0443000};
    vecs[1] = '{op: 5'h19, rd: 5'd5,  rs: 5'd9,  rt: 5'd7,  lit: 12'h7FF, word: 32'hC94007FF};
    vecs[2] = '{op: 5'h10, rd: 5'd31, rs: 5'd31, rt: 5'd31, lit: 12'hFFF, word: 32'h87FE0FFF};
    vecs[3] = '{op: 5'h00, rd: 5'd1,  rs: 5'd2,  rt: 5'd3,  lit: 12'hABC, word: 32'h00443000};
    vecs[4] = '{op: 5'h1D, rd: 5'd7,  rs: 5'd8,  rt: 5'd9,  lit: 12'h123, word: 32'hE9D09000};
    vecs[5] = '{op: 5'h0A, rd: 5'd2,  rs: 5'd4,  rt: 5'd6,  lit: 12'h555, word: 32'h50880555};
    halt_v  = '{op: 5'h0F, rd: 5'd3,  rs: 5'd3,  rt: 5'd3,  lit: 12'hABC, word: 32'h78000000};
    abort_v = vecs[0];

    // Reset state
    #2 reset = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      o = obs(s);
      check("rst_we", 64'(o.we), 64'd0);
      check("rst_addr", o.addr, 64'd0);
      check("rst_ready", 64'(o.rdy), 64'd0);
      check("rst_flags", 64'({o.done, o.ef, o.eo, o.busy}), 64'd0);
      check("rst_count_word", 64'({o.cnt, o.word}), 64'd0);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle_ready", 64'(bus0.in_ready), 64'd0);

    // Start, then the encoding table written back to back
    pulse_start(0);
    o = obs(0);
    check("start_ready", 64'(o.rdy), 64'd1);
    check("start_busy", 64'(o.busy), 64'd1);
    check("start_count", 64'(o.cnt), 64'd0);
    exp_addr = 64'h2000;
    exp_cnt  = 16'd0;
    for (int i = 0; i < 6; i++) begin
      exp_cnt = exp_cnt + 16'd1;
      send(0, vecs[i], exp_addr, exp_cnt, 1'b0, 1'b0);
      exp_addr = exp_addr + 64'd4;
    end

    // Halt ends the program with a one-cycle done pulse
    exp_cnt = exp_cnt + 16'd1;
    send(0, halt_v, exp_addr, exp_cnt, 1'b1, 1'b0);
    tick();
    check("done_clears", 64'(d0), 64'd0);

    // Tuples offered while IDLE are ignored
    in_opcode = 5'h18;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_no_we", 64'(bus0.mem_we), 64'd0);
    end
    in_valid = 1'b0;
    check("idle_count", 64'(c0), 64'(exp_cnt));

    // Illegal opcodes 0x1E and 0x1F: flagged, never written
    pulse_start(0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_opcode = (i < 2) ? 5'h1E : 5'h1F;
      tick();
      check("illegal_no_we", 64'(bus0.mem_we), 64'd0);
      check("illegal_ready", 64'(bus0.in_ready), 64'd1);
    end
    in_valid = 1'b0;
    check("illegal_err", 64'(eo0), 64'd1);
    check("illegal_count", 64'(c0), 64'd0);

    // Start pulsed during byte 1 aborts the word
    in_opcode = abort_v.op; in_rd = abort_v.rd; in_rs = abort_v.rs; in_rt = abort_v.rt; in_lit = abort_v.lit;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("abort_byte1_addr", bus0.mem_addr, 64'h2001);
    start_v[0] = 1'b1;
    tick();
    start_v = '0;
    check("abort_we", 64'(bus0.mem_we), 64'd0);
    check("abort_count", 64'(c0), 64'd0);
    check("abort_ready", 64'(bus0.in_ready), 64'd1);
    check("abort_err_cleared", 64'(eo0), 64'd0);
    send(0, vecs[1], 64'h2000, 16'd1, 1'b0, 1'b0);

    // Small memory: second word fills it
    pulse_start(1);
    check("full_start_ready", 64'(bus1.in_ready), 64'd1);
    send(1, vecs[0], 64'h2000, 16'd1, 1'b0, 1'b0);
    send(1, vecs[1], 64'h2004, 16'd2, 1'b0, 1'b1);
    in_opcode = 5'h18;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_no_we", 64'(bus1.mem_we), 64'd0);
      check("full_ready", 64'(bus1.in_ready), 64'd0);
    end
    in_valid = 1'b0;

    // Memory too small for even one word at BASE_ADDR
    pulse_start(2);
    o = obs(2);
    check("nofit_err_full", 64'(o.ef), 64'd1);
    check("nofit_ready", 64'(o.rdy), 64'd0);
    check("nofit_busy", 64'(o.busy), 64'd0);

    // Asynchronous reset in the middle of a word
    pulse_start(0);
    in_opcode = abort_v.op; in_rd = abort_v.rd; in_rs = abort_v.rs; in_rt = abort_v.rt; in_lit = abort_v.lit;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("rstmid_we_before", 64'(bus0.mem_we), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rstmid_we", 64'(bus0.mem_we), 64'd0);
    check("rstmid_word", 64'(w0), 64'd0);
    check("rstmid_busy", 64'(b0), 64'd0);
    check("rstmid_addr", bus0.mem_addr, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
